// File: rtl/store_gen.sv
// store_gen: replays a small table of (address, data) store beats onto a
// memwrite/dataadr/writedata bus, with a programmable idle gap between beats.
//
// Ports
//   clk         single clock, rising-edge
//   reset       asynchronous, active-low reset
//   start       one-cycle replay request (IDLE only)
//   ready       memory accept; a beat transfers when memwrite & ready
//   cfg_we      table write strobe (IDLE only), entry cfg_idx <= {cfg_addr, cfg_data}
//   cfg_idx     table entry index (bits above log2(DEPTH) ignored)
//   cfg_addr    store address for the written entry
//   cfg_data    store data for the written entry
//   cfg_len_we  length register write strobe (IDLE only)
//   cfg_len     replay length, saturated to DEPTH
//   memwrite    registered beat valid
//   dataadr     registered store address, 0 when memwrite=0
//   writedata   registered store data, 0 when memwrite=0
//   busy        high in every state but IDLE
//   done        one-cycle pulse once a replay completes
//   count       beats transferred in the current/last replay
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; configuration writes accepted
// ST_ISSUE | beat idx presented, held until ready
// ST_GAP   | GAP idle cycles between beats (gcnt counts down to 0)
// ST_DONE  | done pulse, then back to IDLE
module store_gen #(
    parameter int DEPTH = 16,
    parameter int GAP   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ready,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_idx,
    input  logic [31:0] cfg_addr,
    input  logic [31:0] cfg_data,
    input  logic        cfg_len_we,
    input  logic [4:0]  cfg_len,
    output logic        memwrite,
    output logic [31:0] dataadr,
    output logic [31:0] writedata,
    output logic        busy,
    output logic        done,
    output logic [4:0]  count
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_GAP, ST_DONE} state_t;

    state_t      state, state_d;
    logic [4:0]  idx, idx_d, idx_inc, count_d;
    logic [3:0]  gcnt, gcnt_d;
    logic        mw_d;
    logic [31:0] adr_d, dat_d;

    logic [31:0] tab_addr [DEPTH];
    logic [31:0] tab_data [DEPTH];
    logic [4:0]  len_q;

    logic          cfg_ok;
    logic [IW-1:0] widx;
    logic [4:0]    len_sat, len_eff;
    logic [31:0]   first_addr, first_data;

    assign cfg_ok  = (state == ST_IDLE);
    assign widx    = cfg_idx[IW-1:0];
    assign len_sat = (cfg_len > 5'(DEPTH)) ? 5'(DEPTH) : cfg_len;
    assign idx_inc = idx + 5'd1;

    // A write landing on the same edge as start must be seen by the replay,
    // so the length and entry 0 are bypassed from the cfg inputs.
    assign len_eff    = (cfg_ok && cfg_len_we) ? len_sat : len_q;
    assign first_addr = (cfg_ok && cfg_we && widx == '0) ? cfg_addr : tab_addr[0];
    assign first_data = (cfg_ok && cfg_we && widx == '0) ? cfg_data : tab_data[0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                tab_addr[i] <= '0;
                tab_data[i] <= '0;
            end
            tab_addr[0] <= 32'd80;
            tab_addr[1] <= 32'd84;
            tab_data[1] <= 32'd7;
            len_q       <= 5'd2;
        end else begin
            if (cfg_ok && cfg_we) begin
                tab_addr[widx] <= cfg_addr;
                tab_data[widx] <= cfg_data;
            end
            if (cfg_ok && cfg_len_we)
                len_q <= len_sat;
        end
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        count_d = count;
        gcnt_d  = gcnt;
        mw_d    = 1'b0;
        adr_d   = '0;
        dat_d   = '0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    count_d = '0;
                    idx_d   = '0;
                    if (len_eff != '0) begin
                        state_d = ST_ISSUE;
                        mw_d    = 1'b1;
                        adr_d   = first_addr;
                        dat_d   = first_data;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ISSUE: begin
                mw_d  = 1'b1;
                adr_d = dataadr;
                dat_d = writedata;
                if (ready) begin
                    count_d = count + 5'd1;
                    if (idx == len_q - 5'd1) begin
                        state_d = ST_DONE;
                        mw_d    = 1'b0;
                        adr_d   = '0;
                        dat_d   = '0;
                    end else begin
                        idx_d = idx_inc;
                        if (GAP == 0) begin
                            adr_d = tab_addr[idx_inc[IW-1:0]];
                            dat_d = tab_data[idx_inc[IW-1:0]];
                        end else begin
                            state_d = ST_GAP;
                            gcnt_d  = GAP_LOAD;
                            mw_d    = 1'b0;
                            adr_d   = '0;
                            dat_d   = '0;
                        end
                    end
                end
            end
            ST_GAP: begin
                if (gcnt == 4'd0) begin
                    state_d = ST_ISSUE;
                    mw_d    = 1'b1;
                    adr_d   = tab_addr[idx[IW-1:0]];
                    dat_d   = tab_data[idx[IW-1:0]];
                end else begin
                    gcnt_d = gcnt - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            gcnt      <= '0;
            count     <= '0;
            memwrite  <= 1'b0;
            dataadr   <= '0;
            writedata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            gcnt      <= gcnt_d;
            count     <= count_d;
            memwrite  <= mw_d;
            dataadr   <= adr_d;
            writedata <= dat_d;
            busy      <= (state_d != ST_IDLE);
            done      <= (state_d == ST_DONE);
        end
    end

endmodule

// File: doc/store_gen.md
STORE_GEN -- requirements
Module: store_gen

Interface
REQ-001 Parameter DEPTH, default 16, number of store-table entries (power of two, 2..16).
REQ-002 Parameter GAP, default 1, idle cycles inserted between consecutive store beats (0..15).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; asserting it (low) clears all state immediately, independent of clk.
REQ-005 start  input  1  one-cycle request to replay the store table; honoured only in IDLE.
REQ-006 ready  input  1  memory-side accept; a beat transfers on a rising edge where memwrite=1 and ready=1.
REQ-007 cfg_we  input  1  table write strobe; honoured only in IDLE.
REQ-008 cfg_idx  input  4  table entry index for cfg_we; bits above log2(DEPTH) ignored.
REQ-009 cfg_addr  input  32  store address to load into entry cfg_idx.
REQ-010 cfg_data  input  32  store data to load into entry cfg_idx.
REQ-011 cfg_len_we  input  1  length-register write strobe; honoured only in IDLE.
REQ-012 cfg_len  input  5  number of entries to replay (0..DEPTH); values above DEPTH saturate to DEPTH.
REQ-013 memwrite  output  1  store-beat valid, registered.
REQ-014 dataadr  output  32  store address, registered, stable while memwrite=1.
REQ-015 writedata  output  32  store data, registered, stable while memwrite=1.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse after the last beat, or after an empty replay.
REQ-018 count  output  5  number of beats transferred in the current/last replay.

Function
REQ-019 FSM states: IDLE, ISSUE, GAP, DONE.
REQ-020 IDLE: start=1 with len>0 -> ISSUE; start=1 with len=0 -> DONE; count cleared to 0 on start.
REQ-021 ISSUE: memwrite=1, dataadr/writedata = table[idx]; without ready, hold all outputs unchanged (no timeout).
REQ-022 ISSUE transfer with idx=len-1: count+1, memwrite=0 next cycle, -> DONE.
REQ-023 ISSUE transfer with idx<len-1: count+1, idx+1; GAP=0 -> stay ISSUE with the next entry presented next cycle (back-to-back beats); GAP>0 -> GAP.
REQ-024 GAP: memwrite=0 for exactly GAP cycles, then -> ISSUE.
REQ-025 DONE: done=1 for exactly one cycle, -> IDLE; idx cleared.
REQ-026 start while busy ignored; start in the same cycle as DONE ignored.
REQ-027 cfg_we/cfg_len_we while busy ignored; table and length unchanged.
REQ-028 cfg_we and start in the same IDLE cycle: the table write takes effect first and the replay uses the new entry; same for cfg_len_we.
REQ-029 dataadr and writedata are driven 0 whenever memwrite=0.
REQ-030 Latency: first beat has memwrite=1 in the cycle after start is sampled.

Reset
REQ-031 While reset=0: state IDLE, memwrite=0, dataadr=0, writedata=0, busy=0, done=0, count=0, idx=0.
REQ-032 Reset table contents: entry0=(addr 80, data 0), entry1=(addr 84, data 7), all other entries (0,0); length register = 2.
REQ-033 Reset asserted mid-replay aborts immediately: memwrite drops asynchronously, no done pulse; after release, the FSM waits in IDLE for a new start.

Verification
REQ-034 Reset release, ready=1, start pulse -> memwrite beats (80,0) then (84,7) separated by 1 idle cycle, done pulse, count=2.
REQ-035 GAP=0, len=4, ready=1 -> 4 consecutive memwrite cycles, done in the cycle after the 4th beat, count=4.
REQ-036 ready=0 for 3 cycles on beat 0 -> (80,0) held for 4 cycles, one transfer only, count increments once.
REQ-037 cfg_len=0 then start -> no memwrite, done pulse 1 cycle after start, count=0; cfg_we while busy -> table unchanged on the next replay.
REQ-038 reset low during the GAP after beat 0 -> all outputs 0 immediately, no done; new start replays from entry 0.
